// File: rtl/axi_rd_arbiter.sv
// 2:1 AXI4 read-channel arbiter merging instruction fetch (s0) and data (s1) onto one AXI read master.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority via PRIO_PORT.
module axi_rd_arbiter #(
   parameter int PRIO_PORT  = 1,
   parameter int ERR_STICKY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s0_arvalid,
   output logic        s0_arready,
   input  logic [48:0] s0_ar_pld,
   output logic        s0_rvalid,
   input  logic        s0_rready,
   output logic [34:0] s0_r_pld,
   input  logic        s1_arvalid,
   output logic        s1_arready,
   input  logic [48:0] s1_ar_pld,
   output logic        s1_rvalid,
   input  logic        s1_rready,
   output logic [34:0] s1_r_pld,
   output logic        m_arid,
   output logic        m_arvalid,
   input  logic        m_arready,
   output logic [48:0] m_ar_pld,
   input  logic        m_rid,
   input  logic        m_rvalid,
   output logic        m_rready,
   input  logic [34:0] m_r_pld,
   output logic        err_rid
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t     state, state_nxt;
   logic [1:0] busy, eligible, busy_set, busy_clr;
   logic       win, grant, ar_hs, bad_rid;

   // A port is eligible only against the registered busy bit, so a same-cycle clear waits a cycle.
   assign eligible = {s1_arvalid & ~busy[1], s0_arvalid & ~busy[0]};
   assign grant    = (state == IDLE) & (|eligible);

`ifdef ARB_RR_EN
   logic rr_last;

   always_comb begin
      if (&eligible) win = ~rr_last;
      else           win = eligible[1];
   end

   always_ff @(posedge clk) begin
      if (reset)      rr_last <= 1'b1;
      else if (grant) rr_last <= win;
   end
`else
   always_comb begin
      if (&eligible) win = (PRIO_PORT != 0);
      else           win = eligible[1];
   end
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      state_nxt  = state;
      s0_arready = 1'b0;
      s1_arready = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               state_nxt  = ISSUE;
               s0_arready = ~win;
               s1_arready = win;
            end
         end
         ISSUE: begin
            if (m_arready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign m_arvalid = (state == ISSUE);
   assign ar_hs     = m_arvalid & m_arready;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state    <= IDLE;
         m_arid   <= 1'b0;
         m_ar_pld <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            m_arid   <= win;
            m_ar_pld <= win ? s1_ar_pld : s0_ar_pld;
         end
      end
   end

   // R path is purely combinational, steered by RID and qualified by the owner's busy bit.
   assign s0_rvalid = m_rvalid & ~m_rid & busy[0];
   assign s1_rvalid = m_rvalid &  m_rid & busy[1];
   assign s0_r_pld  = m_rvalid ? m_r_pld : '0;
   assign s1_r_pld  = m_rvalid ? m_r_pld : '0;

   // A beat for an idle port is accepted and discarded so the downstream never stalls on it.
   assign bad_rid  = m_rvalid & ~busy[m_rid];
   assign m_rready = bad_rid | (m_rid ? s1_rready : s0_rready);

   assign busy_set = {ar_hs & m_arid, ar_hs & ~m_arid};
   assign busy_clr = {s1_rvalid & s1_rready & m_r_pld[0], s0_rvalid & s0_rready & m_r_pld[0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 2'b00;
         err_rid <= 1'b0;
      end else begin
         busy <= (busy | busy_set) & ~busy_clr;
         if (ERR_STICKY != 0) err_rid <= err_rid | bad_rid;
         else                 err_rid <= bad_rid;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized self-checking bench for axi_rd_arbiter against a transaction-level reference model.
// Honours ARB_RR_EN the same way as the design.
module tb_axi_rd_arbiter;

   localparam int PRIO_PORT  = 1;
   localparam int ERR_STICKY = 1;

   localparam logic [48:0] P_BOOT = {32'h1FC0_0000, 8'd0, 3'd2, 2'b01, 4'b0011};
   localparam logic [48:0] P_INST = {32'h0000_1000, 8'd3, 3'd2, 2'b01, 4'b0011};
   localparam logic [48:0] P_DATA = {32'h8000_0040, 8'd0, 3'd2, 2'b01, 4'b1111};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
   logic [48:0] s0_ar_pld;
   logic [34:0] s0_r_pld;
   logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
   logic [48:0] s1_ar_pld;
   logic [34:0] s1_r_pld;
   logic        m_arid, m_arvalid, m_arready, m_rid, m_rvalid, m_rready, err_rid;
   logic [48:0] m_ar_pld;
   logic [34:0] m_r_pld;

   axi_rd_arbiter #(.PRIO_PORT(PRIO_PORT), .ERR_STICKY(ERR_STICKY)) dut (
      .clk(clk), .reset(reset),
      .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_ar_pld(s0_ar_pld),
      .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_r_pld(s0_r_pld),
      .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_ar_pld(s1_ar_pld),
      .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_r_pld(s1_r_pld),
      .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar_pld(m_ar_pld),
      .m_rid(m_rid), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r_pld(m_r_pld),
      .err_rid(err_rid)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one pending AR slot, per-port outstanding flags, error flag, last grant.
   int          pend_port = -1;
   logic [48:0] pld_m     = '0;
   bit          arid_m    = 1'b0;
   bit          out_m [2] = '{1'b0, 1'b0};
   bit          err_m     = 1'b0;
   bit          last_m    = 1'b1;

   function automatic int pick(input bit e0, input bit e1);
      if (e0 && e1) begin
`ifdef ARB_RR_EN
         return last_m ? 0 : 1;
`else
         return PRIO_PORT;
`endif
      end
      if (e0) return 0;
      if (e1) return 1;
      return -1;
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, then advance the model.
   task automatic step(input bit rst, input bit a0v, input logic [48:0] a0p,
                       input bit a1v, input logic [48:0] a1p, input bit arrdy,
                       input bit rv, input bit rid, input logic [34:0] rp,
                       input bit rr0, input bit rr1);
      int win;
      bit exp_rv0, exp_rv1, bad, exp_rr;
      bit done [2];
      reset = rst;  s0_arvalid = a0v;  s0_ar_pld = a0p;  s1_arvalid = a1v;  s1_ar_pld = a1p;
      m_arready = arrdy;  m_rvalid = rv;  m_rid = rid;  m_r_pld = rp;
      s0_rready = rr0;  s1_rready = rr1;
      #2;
      win = (pend_port < 0) ? pick(a0v && !out_m[0], a1v && !out_m[1]) : -1;
      check("s0_arready", s0_arready, win == 0);
      check("s1_arready", s1_arready, win == 1);
      check("m_arvalid", m_arvalid, pend_port >= 0);
      check("m_arid", m_arid, arid_m);
      check("m_ar_pld", m_ar_pld, pld_m);
      exp_rv0 = rv && !rid && out_m[0];
      exp_rv1 = rv &&  rid && out_m[1];
      bad     = rv && !out_m[rid];
      exp_rr  = bad ? 1'b1 : (rid ? rr1 : rr0);
      check("s0_rvalid", s0_rvalid, exp_rv0);
      check("s1_rvalid", s1_rvalid, exp_rv1);
      check("m_rready", m_rready, exp_rr);
      check("s0_r_pld", s0_r_pld, rv ? rp : 35'd0);
      check("s1_r_pld", s1_r_pld, rv ? rp : 35'd0);
      check("err_rid", err_rid, err_m);
      @(posedge clk);
      if (rst) begin
         pend_port = -1;  pld_m = '0;  arid_m = 1'b0;
         out_m[0] = 1'b0;  out_m[1] = 1'b0;  err_m = 1'b0;  last_m = 1'b1;
      end else begin
         done[0] = exp_rv0 && rr0 && rp[0];
         done[1] = exp_rv1 && rr1 && rp[0];
         if (pend_port >= 0 && arrdy) begin
            out_m[pend_port] = 1'b1;
            pend_port = -1;
         end else if (win >= 0) begin
            pend_port = win;
            arid_m    = win[0];
            pld_m     = win[0] ? a1p : a0p;
            last_m    = win[0];
         end
         for (int i = 0; i < 2; i++) if (done[i]) out_m[i] = 1'b0;
         err_m = (ERR_STICKY != 0) ? (err_m | bad) : bad;
      end
      #1;
   endtask

   initial begin
      logic [63:0] r64a, r64b;
      logic [34:0] beat;
      bit          rid_sel;

      reset = 1'b1;  s0_arvalid = 1'b0;  s0_ar_pld = '0;  s1_arvalid = 1'b0;  s1_ar_pld = '0;
      m_arready = 1'b0;  m_rvalid = 1'b0;  m_rid = 1'b0;  m_r_pld = '0;
      s0_rready = 1'b0;  s1_rready = 1'b0;
      @(posedge clk);
      #1;

      // Reset state.
      step(1, 0, '0, 0, '0, 0, 0, 0, '0, 0, 0);
      step(0, 0, '0, 0, '0, 0, 0, 0, '0, 0, 0);

      // Lone boot fetch from s0, handshake, then its single R beat.
      step(0, 1, P_BOOT, 0, '0, 0, 0, 0, '0, 0, 0);
      step(0, 0, '0, 0, '0, 1, 0, 0, '0, 0, 0);
      step(0, 0, '0, 0, '0, 0, 1, 0, {32'h3C08_0000, 2'b00, 1'b1}, 1, 0);

      // Same-cycle conflict, downstream stalls 5 cycles, then s0 follows.
      step(0, 1, P_INST, 1, P_DATA, 0, 0, 0, '0, 0, 0);
      repeat (5) step(0, 1, P_INST, 1, P_DATA, 0, 0, 0, '0, 0, 0);
      step(0, 1, P_INST, 1, P_DATA, 1, 0, 0, '0, 0, 0);
      step(0, 1, P_INST, 1, P_DATA, 0, 0, 0, '0, 0, 0);
      step(0, 0, '0, 0, '0, 1, 0, 0, '0, 0, 0);

      // Both outstanding: rid 1 back-pressured 3 cycles, then two beats, then rid 0.
      repeat (3) step(0, 0, '0, 0, '0, 0, 1, 1, {32'hDEAD_0001, 2'b00, 1'b0}, 1, 0);
      step(0, 0, '0, 0, '0, 0, 1, 1, {32'hDEAD_0001, 2'b00, 1'b0}, 1, 1);
      step(0, 0, '0, 0, '0, 0, 1, 1, {32'hDEAD_0002, 2'b00, 1'b1}, 1, 1);
      step(0, 0, '0, 0, '0, 0, 1, 0, {32'hBEEF_0003, 2'b00, 1'b1}, 1, 1);

      // Stray beat for an idle port, then reset while a grant sits in ISSUE.
      step(0, 0, '0, 0, '0, 0, 1, 0, {32'h0BAD_0000, 2'b10, 1'b1}, 0, 0);
      step(0, 0, '0, 0, '0, 0, 0, 0, '0, 0, 0);
      step(0, 1, P_INST, 0, '0, 0, 0, 0, '0, 0, 0);
      step(1, 0, '0, 0, '0, 0, 0, 0, '0, 0, 0);
      step(0, 0, '0, 0, '0, 0, 0, 0, '0, 0, 0);

      // Both ports requesting continuously with reads completing promptly.
      repeat (16) begin
         rid_sel = !out_m[0];
         step(0, 1, P_INST, 1, P_DATA, 1, out_m[0] || out_m[1], rid_sel,
              {32'h1234_5678, 2'b00, 1'b1}, 1, 1);
      end

      // Randomized traffic with occasional resets.
      repeat (4000) begin
         r64a = {$urandom(), $urandom()};
         r64b = {$urandom(), $urandom()};
         if ((out_m[0] || out_m[1]) && $urandom_range(0, 9) != 0)
            rid_sel = out_m[1] && (!out_m[0] || $urandom_range(0, 1) == 1);
         else
            rid_sel = 1'($urandom_range(0, 1));
         beat = {$urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0)};
         step($urandom_range(0, 299) == 0,
              1'($urandom_range(0, 1)), r64a[48:0],
              1'($urandom_range(0, 1)), r64b[48:0],
              $urandom_range(0, 2) != 0,
              1'($urandom_range(0, 1)), rid_sel, beat,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
